s2e_vc_packet_scheduler: RTL and testbench

// Packet-granular VC scheduler for the s2e stream path. It picks which VC (prio*vc_num+vc) may send the next packet.

---
 rtl/s2e_vc_packet_scheduler_if.sv | 27 ++
 rtl/s2e_vc_packet_scheduler.sv | 179 +++++++++++++++++
 tb/tb_s2e_vc_packet_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/s2e_vc_packet_scheduler_if.sv
// Grant/stream interface of the s2e VC packet scheduler.
// The scheduler observes the granted stream's AXI-Stream handshake and
// publishes the active packet grant. The signal names match the scheduler's
// port names.
interface s2e_vc_packet_scheduler_if #(
   parameter int N   = 4,
   parameter int VCW = 2
);
   logic           i_tvalid;
   logic           i_tready;
   logic           i_tlast;
   logic           o_grant_valid;
   logic [VCW-1:0] o_grant_vc;
   logic [N-1:0]   o_grant_1h;

   // Scheduler side: it watches the stream and drives the grant.
   modport slave (
      input  i_tvalid, i_tready, i_tlast,
      output o_grant_valid, o_grant_vc, o_grant_1h
   );

   // Stream/generator side: it drives the handshake and follows the grant.
   modport master (
      output i_tvalid, i_tready, i_tlast,
      input  o_grant_valid, o_grant_vc, o_grant_1h
   );
endinterface

// File: rtl/s2e_vc_packet_scheduler.sv
// Packet-granular VC scheduler for the s2e stream path.
// Arbitration uses strict priority across levels and round-robin within a
// level. Each VC has a packet credit count. A grant is held until the
// granted packet's TLAST handshake, followed by an optional idle gap.
module s2e_vc_packet_scheduler #(
   parameter int prio_num   = 2,
   parameter int vc_num     = 2,
   parameter int CREDIT_MAX = 3,
   parameter int GAP_CYCLES = 2
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [prio_num*vc_num-1:0]   i_req,
   input  logic [prio_num*vc_num-1:0]   i_credit_ret,
   s2e_vc_packet_scheduler_if.slave     bus,
   output logic [prio_num*vc_num-1:0]   o_vc_full,
   output logic                         o_credit_err
);

   localparam int N        = prio_num * vc_num;
   localparam int VCW      = (N > 1) ? $clog2(N) : 1;
   localparam int CW       = $clog2(CREDIT_MAX + 1);
   localparam int PW       = (vc_num > 1) ? $clog2(vc_num) : 1;
   localparam int PRW      = (prio_num > 1) ? $clog2(prio_num) : 1;
   localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_grant_valid;
   logic [VCW-1:0]  r_grant_vc;
   logic [N-1:0]    r_grant_1h;
   logic [PW-1:0]   r_rr_ptr [prio_num];
   logic [GW-1:0]   r_gap_cnt;
   logic [CW-1:0]   r_credit [N];
   logic [N-1:0]    r_vc_full;
   logic            r_credit_err;

   logic [N-1:0]    w_elig;
   logic            w_any;
   logic [VCW-1:0]  w_win_idx;
   logic [PW-1:0]   w_win_vc;
   logic [PRW-1:0]  w_win_prio;
   logic [N-1:0]    w_win_1h;
   logic [PW-1:0]   w_next_ptr;
   logic            w_grant_fire;
   logic            w_beat_last;
   logic [CW-1:0]   w_credit_nxt [N];
   logic            w_err_set;
   int              w_rr_vc;

   // A VC may compete only when it has a packet ready and a free downstream slot.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_elig[i] = i_req[i] & (r_credit[i] != '0);
      end
   end

   // Winner selection: highest level with any eligible VC, round-robin inside it.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      w_any      = 1'b0;
      w_win_idx  = '0;
      w_win_vc   = '0;
      w_win_prio = '0;
      w_rr_vc    = 0;
      // NOTE: blocking assignments here, so later iterations see w_any already set by an earlier one.
      for (int p = prio_num - 1; p >= 0; p--) begin
         for (int k = 0; k < vc_num; k++) begin
            w_rr_vc = (int'(r_rr_ptr[p]) + k) % vc_num;
            if (!w_any && w_elig[p*vc_num + w_rr_vc]) begin
               w_any      = 1'b1;
               w_win_idx  = VCW'(p*vc_num + w_rr_vc);
               w_win_vc   = PW'(w_rr_vc);
               w_win_prio = PRW'(p);
            end
         end
      end
   end

   assign w_win_1h     = N'(1) << w_win_idx;
   assign w_next_ptr   = (w_win_vc == PW'(vc_num - 1)) ? '0 : w_win_vc + PW'(1);
   assign w_grant_fire = (r_state == ST_ARB) && w_any;
   assign w_beat_last  = bus.i_tvalid & bus.i_tready & bus.i_tlast;

   // Next credit per VC: a grant takes a slot, a return frees one, both at once cancel.
   always_comb begin
      w_err_set = 1'b0;
      for (int i = 0; i < N; i++) begin
         w_credit_nxt[i] = r_credit[i];
         if (w_grant_fire && w_win_1h[i] && !i_credit_ret[i]) begin
            w_credit_nxt[i] = r_credit[i] - CW'(1);
         end else if (i_credit_ret[i] && !(w_grant_fire && w_win_1h[i])) begin
            if (r_credit[i] == CW'(CREDIT_MAX)) begin
               w_err_set = 1'b1;
            end else begin
               w_credit_nxt[i] = r_credit[i] + CW'(1);
            end
         end
      end
   end

   // Credit counters, the registered full flags and the sticky overflow flag.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         // NOTE: this small array is reset because its reset value (all slots free) is functional; a data memory would not need it.
         for (int i = 0; i < N; i++) begin
            r_credit[i] <= CW'(CREDIT_MAX);
         end
         r_vc_full    <= '0;
         r_credit_err <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            r_credit[i]  <= w_credit_nxt[i];
            r_vc_full[i] <= (w_credit_nxt[i] == '0);
         end
         if (w_err_set) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   // Grant FSM: arbitrate, hold the grant until the TLAST handshake, then idle for the gap.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state       <= ST_ARB;
         r_grant_valid <= 1'b0;
         r_grant_vc    <= '0;
         r_grant_1h    <= '0;
         r_gap_cnt     <= '0;
         for (int p = 0; p < prio_num; p++) begin
            r_rr_ptr[p] <= '0;
         end
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_any) begin
                  r_state              <= ST_XFER;
                  r_grant_valid        <= 1'b1;
                  r_grant_vc           <= w_win_idx;
                  r_grant_1h           <= w_win_1h;
                  r_rr_ptr[w_win_prio] <= w_next_ptr;
               end
            end
            ST_XFER: begin
               if (w_beat_last) begin
                  r_grant_valid <= 1'b0;
                  r_grant_1h    <= '0;
                  r_gap_cnt     <= '0;
                  r_state       <= (GAP_CYCLES > 0) ? ST_GAP : ST_ARB;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GW'(GAP_LAST)) begin
                  r_gap_cnt <= '0;
                  r_state   <= ST_ARB;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GW'(1);
               end
            end
            default: begin
               r_state <= ST_ARB;
            end
         endcase
      end
   end

   assign bus.o_grant_valid = r_grant_valid;
   assign bus.o_grant_vc    = r_grant_vc;
   assign bus.o_grant_1h    = r_grant_1h;
   assign o_vc_full         = r_vc_full;
   assign o_credit_err      = r_credit_err;

endmodule

// File: tb/tb_s2e_vc_packet_scheduler.sv
// Testbench for s2e_vc_packet_scheduler (prio_num=2, vc_num=2, CREDIT_MAX=3, GAP_CYCLES=2).
// The directed stimulus pushes the expected grant VC into a queue. A monitor
// pops and compares entries as grants appear.
module tb_s2e_vc_packet_scheduler;

   logic       ACLK;
   logic       ARESET;
   logic [3:0] i_req;
   logic [3:0] i_credit_ret;
   logic [3:0] o_vc_full;
   logic       o_credit_err;

   int total = 0;
   int bad   = 0;
   int exp_q [$];

   s2e_vc_packet_scheduler_if #(.N(4), .VCW(2)) bus ();

   s2e_vc_packet_scheduler #(
      .prio_num   (2),
      .vc_num     (2),
      .CREDIT_MAX (3),
      .GAP_CYCLES (2)
   ) dut (
      .ACLK         (ACLK),
      .ARESET       (ARESET),
      .i_req        (i_req),
      .i_credit_ret (i_credit_ret),
      .bus          (bus),
      .o_vc_full    (o_vc_full),
      .o_credit_err (o_credit_err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Monitor: pops the scoreboard on each new grant and checks that the grant is held and the one-hot code is clean.
   logic       prev_valid = 1'b0;
   logic [1:0] held_vc    = '0;
   always @(negedge ACLK) begin
      logic [3:0] exp_1h;
      int         e;
      if (bus.o_grant_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            flag("unexpected_grant");
         end else begin
            e      = exp_q.pop_front();
            exp_1h = 4'b0001 << e;
            check("grant_vc", 32'(bus.o_grant_vc), 32'(e));
            check("grant_1h", 32'(bus.o_grant_1h), 32'(exp_1h));
         end
         held_vc = bus.o_grant_vc;
      end else if (bus.o_grant_valid) begin
         check("grant_vc_held", 32'(bus.o_grant_vc), 32'(held_vc));
      end else begin
         check("grant_1h_idle", 32'(bus.o_grant_1h), 32'd0);
      end
      prev_valid = bus.o_grant_valid;
   end

   task automatic do_reset();
      @(negedge ACLK);
      ARESET       = 1'b1;
      i_req        = '0;
      i_credit_ret = '0;
      bus.i_tvalid = 1'b0;
      bus.i_tready = 1'b0;
      bus.i_tlast  = 1'b0;
      @(negedge ACLK);
      ARESET = 1'b0;
   endtask

   task automatic wait_grant(output bit ok);
      int n = 0;
      while (!bus.o_grant_valid && n < 40) begin
         @(negedge ACLK);
         n++;
      end
      ok = bus.o_grant_valid;
      if (!ok) flag("grant_timeout");
   endtask

   // Drives one packet on the granted stream. The last beat can be stalled with TREADY low.
   task automatic send_packet(input int beats, input int stall);
      bit ok;
      wait_grant(ok);
      if (!ok) return;
      for (int b = 0; b < beats; b++) begin
         bus.i_tvalid = 1'b1;
         bus.i_tready = 1'b1;
         bus.i_tlast  = (b == beats - 1);
         if (b == beats - 1 && stall > 0) begin
            bus.i_tready = 1'b0;
            for (int s = 0; s < stall; s++) begin
               @(negedge ACLK);
               check("grant_held_in_stall", 32'(bus.o_grant_valid), 32'd1);
            end
            bus.i_tready = 1'b1;
         end
         @(negedge ACLK);
      end
      bus.i_tvalid = 1'b0;
      bus.i_tready = 1'b0;
      bus.i_tlast  = 1'b0;
      check("grant_end_after_tlast", 32'(bus.o_grant_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      ARESET       = 1'b1;
      i_req        = '0;
      i_credit_ret = '0;
      bus.i_tvalid = 1'b0;
      bus.i_tready = 1'b0;
      bus.i_tlast  = 1'b0;

      // 1: reset state, round-robin at prio0, credit exhaustion
      do_reset();
      check("rst_grant_valid", 32'(bus.o_grant_valid), 32'd0);
      check("rst_grant_vc",    32'(bus.o_grant_vc),    32'd0);
      check("rst_vc_full",     32'(o_vc_full),         32'd0);
      check("rst_credit_err",  32'(o_credit_err),      32'd0);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
      i_req = 4'b0011;
      @(negedge ACLK);
      check("req_to_grant_1cycle", 32'(bus.o_grant_valid), 32'd1);
      for (int k = 0; k < 6; k++) send_packet(18, 0);
      repeat (10) @(negedge ACLK);
      check("t1_no_grant_when_full", 32'(bus.o_grant_valid), 32'd0);
      check("t1_vc_full",            32'(o_vc_full),         32'b0011);
      check("t1_sb_empty",           32'(exp_q.size()),      32'd0);

      // 2: strict priority, then the lower level
      do_reset();
      exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(3);
      i_req = 4'b1111;
      for (int k = 0; k < 4; k++) send_packet(18, 0);
      i_req = 4'b0011;
      exp_q.push_back(0); exp_q.push_back(1);
      for (int k = 0; k < 2; k++) send_packet(18, 0);
      i_req = 4'b0000;
      repeat (6) @(negedge ACLK);
      check("t2_vc_full",  32'(o_vc_full),    32'd0);
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // 3: a return in the same cycle as the grant on vc2 leaves the credit unchanged
      do_reset();
      exp_q.push_back(2); exp_q.push_back(2);
      i_req = 4'b0100;
      for (int k = 0; k < 2; k++) send_packet(18, 0);
      i_req = 4'b0000;
      repeat (5) @(negedge ACLK);
      check("t3_vc2_credit1_not_full", 32'(o_vc_full), 32'd0);
      exp_q.push_back(2);
      i_req        = 4'b0100;
      i_credit_ret = 4'b0100;
      @(negedge ACLK);
      i_credit_ret = 4'b0000;
      check("t3_full_after_grant_ret", 32'(o_vc_full),    32'd0);
      check("t3_no_credit_err",        32'(o_credit_err), 32'd0);
      send_packet(18, 0);
      i_req = 4'b0000;
      repeat (5) @(negedge ACLK);
      check("t3_still_credit1", 32'(o_vc_full), 32'd0);
      exp_q.push_back(2);
      i_req = 4'b0100;
      send_packet(18, 0);
      i_req = 4'b0000;
      repeat (5) @(negedge ACLK);
      check("t3_vc2_full", 32'(o_vc_full),    32'b0100);
      check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // 4: a return at CREDIT_MAX sets the sticky error and the credit stays at 3
      do_reset();
      i_credit_ret = 4'b0010;
      @(negedge ACLK);
      i_credit_ret = 4'b0000;
      check("t4_credit_err_set", 32'(o_credit_err), 32'd1);
      check("t4_vc_full_none",   32'(o_vc_full),    32'd0);
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
      i_req = 4'b0010;
      for (int k = 0; k < 3; k++) send_packet(18, 0);
      i_req = 4'b0000;
      repeat (8) @(negedge ACLK);
      check("t4_vc1_full_after3",  32'(o_vc_full),    32'b0010);
      check("t4_credit_err_stick", 32'(o_credit_err), 32'd1);
      check("t4_sb_empty",         32'(exp_q.size()), 32'd0);
      do_reset();
      check("t4_credit_err_clear", 32'(o_credit_err), 32'd0);

      // 5: TLAST stalled by TREADY, then the gap before the next grant
      exp_q.push_back(0);
      i_req = 4'b0001;
      send_packet(18, 4);
      exp_q.push_back(0);
      n = 0;
      while (!bus.o_grant_valid && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      check("t5_gap_to_next_grant", 32'(n), 32'd3);
      send_packet(18, 0);
      i_req = 4'b0000;
      repeat (5) @(negedge ACLK);
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // 6: reset in the middle of a packet
      do_reset();
      exp_q.push_back(0);
      i_req = 4'b0001;
      wait_grant(ok);
      for (int b = 0; b < 9; b++) begin
         bus.i_tvalid = 1'b1;
         bus.i_tready = 1'b1;
         bus.i_tlast  = 1'b0;
         @(negedge ACLK);
      end
      ARESET       = 1'b1;
      i_req        = 4'b0000;
      bus.i_tvalid = 1'b0;
      bus.i_tready = 1'b0;
      @(negedge ACLK);
      ARESET = 1'b0;
      check("t6_grant_dropped", 32'(bus.o_grant_valid), 32'd0);
      check("t6_grant_1h_zero", 32'(bus.o_grant_1h),    32'd0);
      check("t6_grant_vc_zero", 32'(bus.o_grant_vc),    32'd0);
      check("t6_vc_full_zero",  32'(o_vc_full),         32'd0);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      i_req = 4'b0001;
      for (int k = 0; k < 3; k++) send_packet(18, 0);
      i_req = 4'b0000;
      repeat (8) @(negedge ACLK);
      check("t6_credits_were_3", 32'(o_vc_full),    32'b0001);
      check("t6_sb_empty",       32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
